rom_fetch_ctrl: RTL and testbench

//  Fetch controller between a requester (core I-fetch / boot loader) and the synchronous-read ROM.

---
 rtl/rom_fetch_pkg.sv | 23 ++
 rtl/rom_fetch_ctrl.sv | 104 ++++++++++
 tb/tb_rom_fetch_ctrl.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/rom_fetch_pkg.sv
// Shared types and address helpers for the ROM fetch controller.
package rom_fetch_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_e;

  function automatic int unsigned lane_bits(input int unsigned width);
    return $clog2(width / 8);
  endfunction

  localparam int unsigned DEF_WIDTH     = 32;
  localparam int unsigned DEF_LANE_BITS = $clog2(DEF_WIDTH / 8);

  // Byte address to word offset relative to the ROM base; wraps below the base.
  function automatic logic [63:0] word_offset(input logic [63:0] addr,
                                              input logic [63:0] base,
                                              input int unsigned width);
    return (addr - base) >> lane_bits(width);
  endfunction

endpackage

// File: rtl/rom_fetch_ctrl.sv
// Valid/ready fetch front-end for a synchronous-read ROM, one fetch per cycle.
// Optional address checking is enabled with the ROM_FETCH_ERR_EN macro.
module rom_fetch_ctrl
  import rom_fetch_pkg::*;
#(
  parameter int unsigned   WIDTH     = 32,
  parameter int unsigned   DEPTH     = 1024,
  parameter int unsigned   AW        = 32,
  parameter logic [AW-1:0] BASE_ADDR = '0,
  parameter int unsigned   TAG_W     = 4
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic                     req_val,
  output logic                     req_rdy,
  input  logic [AW-1:0]            req_addr,
  input  logic [TAG_W-1:0]         req_tag,
  input  logic                     flush,
  output logic                     resp_val,
  input  logic                     resp_rdy,
  output logic [WIDTH-1:0]         resp_data,
  output logic [TAG_W-1:0]         resp_tag,
  output logic                     resp_err,
  output logic                     rom_en,
  output logic [$clog2(DEPTH)-1:0] rom_addr,
  input  logic [WIDTH-1:0]         rom_do,
  output logic [31:0]              fetch_cnt
);

  localparam int unsigned IW = $clog2(DEPTH);
  localparam int unsigned LB = lane_bits(WIDTH);

  state_e             state_q, state_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic               err_q, err_d;
  logic [31:0]        cnt_q, cnt_d;

  logic               accept;
  logic               err_now;
  logic [IW-1:0]      idx;

`ifdef ROM_FETCH_ERR_EN
  localparam logic [AW-1:0] LOW_MASK = AW'((64'd1 << LB) - 64'd1);
  logic [AW-1:0] off;

  always_comb begin
    off     = AW'(word_offset(64'(req_addr), 64'(BASE_ADDR), WIDTH));
    idx     = off[IW-1:0];
    err_now = (req_addr < BASE_ADDR) | (off >= AW'(DEPTH)) | ((req_addr & LOW_MASK) != '0);
  end
`else
  always_comb begin
    idx     = IW'(word_offset(64'(req_addr), 64'(BASE_ADDR), WIDTH));
    err_now = 1'b0;
  end
`endif

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      tag_q   <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      tag_q   <= tag_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // A new accept always wins; otherwise flush or a taken response drains to IDLE.
  always_comb begin
    state_d = state_q;
    tag_d   = tag_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    if (accept) begin
      state_d = RESP;
      tag_d   = req_tag;
      err_d   = err_now;
      if (cnt_q != '1) cnt_d = cnt_q + 32'd1;
    end else if (state_q == RESP && (flush || resp_rdy)) begin
      state_d = IDLE;
    end
  end

  always_comb begin
    req_rdy   = ~flush & ((state_q == IDLE) | resp_rdy);
    accept    = req_val & req_rdy;
    rom_en    = accept & ~err_now;
    rom_addr  = rom_en ? idx : '0;
    resp_val  = (state_q == RESP);
    resp_tag  = tag_q;
    fetch_cnt = cnt_q;
    resp_data = (resp_val && !err_q) ? rom_do : '0;
`ifdef ROM_FETCH_ERR_EN
    resp_err  = resp_val & err_q;
`else
    resp_err  = 1'b0;
`endif
  end

endmodule

// File: tb/tb_rom_fetch_ctrl.sv
// Randomised bench for rom_fetch_ctrl against a cycle-level transaction model.
module tb_rom_fetch_ctrl;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned DEPTH = 1024;
  localparam int unsigned AW    = 32;
  localparam logic [31:0] BASE  = 32'h0;
  localparam int unsigned TAG_W = 4;

  logic             CLK = 1'b0;
  logic             RST_N;
  logic             req_val, req_rdy, flush, resp_val, resp_rdy, resp_err, rom_en;
  logic [31:0]      req_addr;
  logic [3:0]       req_tag, resp_tag;
  logic [31:0]      resp_data, rom_do, fetch_cnt;
  logic [9:0]       rom_addr;

  logic [31:0]      rom_mem [DEPTH];

  int unsigned      n_cmp = 0;
  int unsigned      n_err = 0;

  bit               m_pend;
  logic [31:0]      m_word;
  logic [3:0]       m_tag;
  bit               m_err;
  longint unsigned  m_cnt;

  rom_fetch_ctrl #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW), .BASE_ADDR(BASE), .TAG_W(TAG_W)
  ) dut (
    .CLK(CLK), .RST_N(RST_N),
    .req_val(req_val), .req_rdy(req_rdy), .req_addr(req_addr), .req_tag(req_tag),
    .flush(flush),
    .resp_val(resp_val), .resp_rdy(resp_rdy), .resp_data(resp_data),
    .resp_tag(resp_tag), .resp_err(resp_err),
    .rom_en(rom_en), .rom_addr(rom_addr), .rom_do(rom_do),
    .fetch_cnt(fetch_cnt)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) if (rom_en) rom_do <= rom_mem[rom_addr];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit addr_err(input logic [31:0] a);
`ifdef ROM_FETCH_ERR_EN
    return (a < BASE) || (((a - BASE) >> 2) >= DEPTH) || (a % 4 != 0);
`else
    return 1'b0;
`endif
  endfunction

  function automatic int unsigned word_idx(input logic [31:0] a);
    return ((a - BASE) / 4) % DEPTH;
  endfunction

  task automatic model_reset();
    m_pend = 0; m_tag = '0; m_err = 0; m_cnt = 0; m_word = '0;
  endtask

  // Called just after a falling edge; returns just after the next falling edge.
  task automatic cycle(input bit v, input logic [31:0] a, input logic [3:0] t,
                       input bit f, input bit r);
    bit rdy, acc, e;
    int unsigned idx;
    req_val = v; req_addr = a; req_tag = t; flush = f; resp_rdy = r;
    #1;
    rdy = !f && (!m_pend || r);
    acc = v && rdy;
    e   = addr_err(a);
    idx = word_idx(a);
    check_eq("req_rdy", req_rdy, rdy);
    check_eq("rom_en", rom_en, acc && !e);
    check_eq("rom_addr", rom_addr, (acc && !e) ? idx : 0);
    check_eq("resp_val", resp_val, m_pend);
    check_eq("resp_err", resp_err, m_pend && m_err);
    if (m_pend) begin
      check_eq("resp_data", resp_data, m_err ? 32'h0 : m_word);
      check_eq("resp_tag", resp_tag, m_tag);
    end
    check_eq("fetch_cnt", fetch_cnt, m_cnt);
    @(posedge CLK);
    if (acc) begin
      m_pend = 1; m_word = rom_mem[idx]; m_tag = t; m_err = e;
      if (m_cnt != 64'hFFFF_FFFF) m_cnt++;
    end else if (f || r) begin
      m_pend = 0;
    end
    @(negedge CLK);
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 3))
      0:       return {20'h0, 10'($urandom_range(0, DEPTH - 1)), 2'b00};
      1:       return $urandom_range(32'hFF0, 32'h1010);
      2:       return $urandom;
      default: return $urandom_range(0, 32'h40);
    endcase
  endfunction

  initial begin
    for (int i = 0; i < DEPTH; i++) rom_mem[i] = $urandom;
    rom_mem[5] = 32'hDEAD_BEEF;
    RST_N = 1'b0; req_val = 0; req_addr = '0; req_tag = '0; flush = 0; resp_rdy = 0;
    model_reset();
    @(negedge CLK); @(negedge CLK);
    #1;
    check_eq("rst_resp_val", resp_val, 0);
    check_eq("rst_resp_tag", resp_tag, 0);
    check_eq("rst_resp_err", resp_err, 0);
    check_eq("rst_fetch_cnt", fetch_cnt, 0);
    check_eq("rst_rom_en", rom_en, 0);
    check_eq("rst_rom_addr", rom_addr, 0);
    @(negedge CLK);
    RST_N = 1'b1;

    // single fetch
    cycle(1, 32'h14, 4'd3, 0, 0);
    #1 check_eq("s1_data", resp_data, 32'hDEAD_BEEF);
    check_eq("s1_tag", resp_tag, 4'd3);
    cycle(0, 0, 0, 0, 1);

    // back-to-back
    cycle(1, 32'h0, 4'd1, 0, 1);
    cycle(1, 32'h4, 4'd2, 0, 1);
    cycle(1, 32'h8, 4'd4, 0, 1);
    cycle(0, 0, 0, 0, 1);
    check_eq("s2_cnt", fetch_cnt, 32'd4);

    // backpressure with competing requests
    cycle(1, 32'h10, 4'd9, 0, 0);
    for (int i = 0; i < 4; i++) cycle(1, rand_addr(), 4'($urandom), 0, 0);
    #1 check_eq("s3_data", resp_data, rom_mem[4]);
    cycle(0, 0, 0, 0, 1);

    // flush while stalled
    cycle(1, 32'h18, 4'd6, 0, 0);
    cycle(1, 32'h1C, 4'd7, 1, 0);
    check_eq("s4_val", resp_val, 0);
    cycle(0, 0, 0, 0, 0);

    // out-of-range and misaligned addresses
    cycle(1, 32'h1000, 4'd5, 0, 1);
    cycle(1, 32'h2, 4'd8, 0, 1);
    cycle(0, 0, 0, 0, 1);

    // asynchronous reset while a response is pending
    cycle(1, 32'h20, 4'd7, 0, 0);
    req_val = 0; resp_rdy = 0;
    #2 RST_N = 1'b0;
    #1;
    check_eq("s6_val", resp_val, 0);
    check_eq("s6_cnt", fetch_cnt, 0);
    model_reset();
    @(negedge CLK);
    RST_N = 1'b1;
    cycle(1, 32'h14, 4'd3, 0, 0);
    cycle(0, 0, 0, 0, 1);

    for (int i = 0; i < 3000; i++)
      cycle($urandom_range(0, 9) < 7, rand_addr(), 4'($urandom),
            $urandom_range(0, 9) == 0, $urandom_range(0, 9) < 7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
